seg_capture: RTL and testbench
==============================

SEG_CAPTURE -- requirements
Module: seg_capture

Interface
REQ-001 The block SHALL have parameter STABLE_CYCLES, default 4, meaning the number of consecutive identical synchronized samples required before a digit is captured (legal range 2..255).
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all logic is rising-edge triggered.
REQ-003 The block SHALL have port rst, input, 1 bit: reset, synchronous, active-high.
REQ-004 The block SHALL have port an_i, input, 4 bits: digit enables, active-low; an_i[k]=0 selects digit k.
REQ-005 The block SHALL have port seg_i, input, 7 bits: segment pattern {g,f,e,d,c,b,a}, active-low.
REQ-006 The block SHALL have port value_o, output, 16 bits: decoded frame; digit k occupies bits [4k+3:4k].
REQ-007 The block SHALL have port err_o, output, 4 bits: err_o[k]=1 means digit k held an unrecognised pattern.
REQ-008 The block SHALL have port valid_o, output, 1 bit: one-cycle pulse marking a new value_o/err_o frame.

Function
REQ-009 The block SHALL pass an_i and seg_i through a two-flop synchronizer before any other use.
REQ-010 Decode table (synchronized seg -> code) SHALL be: 1000000->0, 1111001->1, 0100100->2, 0110000->3, 0011001->4, 0010010->5, 0000010->6, 1111000->7, 0000000->8, 0010000->9, 0000110->10 (E), 1111111->15 (blank, no error).
REQ-011 Any pattern not in REQ-010 SHALL decode to 15 with the digit's error bit set.
REQ-012 Sample pair SHALL mean {an,seg} after synchronization; a sample is eligible only when exactly one an bit is 0.
REQ-013 FSM states SHALL be WAIT (pair ineligible or changing), SETTLE (eligible, counting), HELD (captured, waiting for pair change).
REQ-014 In WAIT, an eligible pair SHALL load the stability counter with 1 and enter SETTLE.
REQ-015 In SETTLE, a pair equal to the previous cycle's pair SHALL increment the counter; a differing eligible pair SHALL reload it to 1; an ineligible pair SHALL go to WAIT.
REQ-016 When the counter reaches STABLE_CYCLES, the block SHALL write the decoded code and error bit into digit slot k in that cycle, set captured-mask bit k, and enter HELD.
REQ-017 In HELD, the same pair SHALL NOT cause re-capture; a differing eligible pair SHALL enter SETTLE with count 1; an ineligible pair SHALL go to WAIT.
REQ-018 Re-capture of a digit whose mask bit is already set SHALL overwrite that slot without completing a frame.
REQ-019 When the captured mask becomes 4'b1111, the block SHALL on the next cycle copy all slots to value_o/err_o, pulse valid_o for exactly one cycle, and clear the mask.
REQ-020 A capture occurring in the same cycle as the mask clear SHALL be kept and set its mask bit in the new (cleared) mask.
REQ-021 value_o and err_o SHALL hold their last frame between valid_o pulses.
REQ-022 Latency SHALL be: input change to capture = 2 (sync) + STABLE_CYCLES cycles; fourth capture to valid_o = 1 cycle.
REQ-023 All outputs SHALL be registered.

Reset
REQ-024 While rst=1 on a clock edge, the block SHALL set value_o=16'h0000, err_o=4'b0000, valid_o=0, mask=0, counter=0, slots=0, synchronizers to {an=4'hF, seg=7'h7F}, FSM=WAIT.
REQ-025 Reset asserted mid-frame SHALL discard partial captures; no valid_o pulse SHALL follow the reset.
REQ-026 The first capture after reset deassertion SHALL occur no earlier than 2+STABLE_CYCLES cycles after the first eligible input.

Verification
REQ-027 Scan an0..an3 low in turn, 8 cycles each, with patterns for 1,2,3,4 -> single valid_o pulse, value_o=16'h4321, err_o=0000.
REQ-028 Hold an_i=4'b1110 with seg changing every 3 cycles (STABLE_CYCLES=4) -> no capture, no valid_o.
REQ-029 Frame with digit 2 showing 0000110 and digit 3 showing 0101010 -> value_o[11:8]=4'hA, value_o[15:12]=4'hF, err_o=1000.
REQ-030 Drive an_i=4'b1100 or 4'b1111 for 20 cycles between valid digits -> ignored; frame still completes with correct value.
REQ-031 Capture digits 0,1,2 then assert rst 1 cycle, then full scan of 5,6,7,8 -> exactly one valid_o, value_o=16'h8765.
REQ-032 Scan digit 0 twice (3 then 9) before digits 1..3 (0,0,0) -> value_o=16'h0009, one valid_o.

Source files
------------

// File: rtl/seg_capture.sv
// -----------------------------------------------------------------------------
// seg_capture
//   Recovers the four digits shown on a multiplexed, active-low 7-segment
//   display bus. The anode/segment pair is synchronized, each digit's pair
//   must hold steady for STABLE_CYCLES samples before it is decoded and stored
//   in its slot. Once all four slots have been captured, the frame is
//   published on value_o/err_o with a single-cycle valid_o pulse.
//
// Parameters
//   STABLE_CYCLES : consecutive identical synchronized samples needed before a
//                   digit is captured (2..255).
//
// Ports
//   clk      : clock, rising edge
//   rst      : synchronous active-high reset
//   an_i     : digit enables, active-low (an_i[k]=0 selects digit k)
//   seg_i    : segments {g,f,e,d,c,b,a}, active-low
//   value_o  : decoded frame, digit k in bits [4k+3:4k]
//   err_o    : err_o[k]=1 when digit k held an unrecognised pattern
//   valid_o  : one-cycle pulse marking a new value_o/err_o frame
// -----------------------------------------------------------------------------
module seg_capture #(
  parameter int STABLE_CYCLES = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  an_i,
  input  logic [6:0]  seg_i,
  output logic [15:0] value_o,
  output logic [3:0]  err_o,
  output logic        valid_o
);

  localparam logic [7:0] STABLE_C = 8'(STABLE_CYCLES);

  typedef enum logic [1:0] {
    ST_WAIT   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_HELD   = 2'd2
  } state_t;

  // Decode an active-low segment pattern into {err, code}.
  function automatic logic [4:0] seg_decode(input logic [6:0] s);
    logic [4:0] r;
    case (s)
      7'b1000000: r = {1'b0, 4'd0};
      7'b1111001: r = {1'b0, 4'd1};
      7'b0100100: r = {1'b0, 4'd2};
      7'b0110000: r = {1'b0, 4'd3};
      7'b0011001: r = {1'b0, 4'd4};
      7'b0010010: r = {1'b0, 4'd5};
      7'b0000010: r = {1'b0, 4'd6};
      7'b1111000: r = {1'b0, 4'd7};
      7'b0000000: r = {1'b0, 4'd8};
      7'b0010000: r = {1'b0, 4'd9};
      7'b0000110: r = {1'b0, 4'd10};
      7'b1111111: r = {1'b0, 4'd15};
      default:    r = {1'b1, 4'd15};
    endcase
    return r;
  endfunction

  // A pair is usable only when exactly one anode is driven low.
  function automatic logic an_eligible(input logic [3:0] a);
    logic r;
    case (a)
      4'b1110, 4'b1101, 4'b1011, 4'b0111: r = 1'b1;
      default:                            r = 1'b0;
    endcase
    return r;
  endfunction

  function automatic logic [1:0] an_index(input logic [3:0] a);
    logic [1:0] r;
    case (a)
      4'b1101: r = 2'd1;
      4'b1011: r = 2'd2;
      4'b0111: r = 2'd3;
      default: r = 2'd0;
    endcase
    return r;
  endfunction

  // Synchronizer, previous-pair and control state
  logic [3:0]  an_s1_q, an_s2_q, an_prev_q;
  logic [6:0]  seg_s1_q, seg_s2_q, seg_prev_q;
  state_t      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [3:0]  mask_q, mask_d;
  logic [15:0] slot_val_q, slot_val_d;
  logic [3:0]  slot_err_q, slot_err_d;
  logic [15:0] value_q, value_d;
  logic [3:0]  err_q, err_d;
  logic        valid_q, valid_d;

  logic        elig;
  logic        same_pair;
  logic        cap;
  logic        frame;
  logic [1:0]  idx;
  logic [4:0]  dec;

  assign elig      = an_eligible(an_s2_q);
  assign same_pair = (an_s2_q == an_prev_q) && (seg_s2_q == seg_prev_q);
  assign idx       = an_index(an_s2_q);
  assign dec       = seg_decode(seg_s2_q);
  assign frame     = (mask_q == 4'hF);

  // Stability FSM: next state and capture strobe
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    cap     = 1'b0;
    case (state_q)
      ST_WAIT: begin
        if (elig) begin
          cnt_d   = 8'd1;
          state_d = ST_SETTLE;
        end
      end
      ST_SETTLE: begin
        if (!elig) begin
          cnt_d   = 8'd0;
          state_d = ST_WAIT;
        end else if (same_pair) begin
          cnt_d = cnt_q + 8'd1;
          if (cnt_d == STABLE_C) begin
            cap     = 1'b1;
            state_d = ST_HELD;
          end
        end else begin
          cnt_d = 8'd1;
        end
      end
      ST_HELD: begin
        if (!elig) begin
          cnt_d   = 8'd0;
          state_d = ST_WAIT;
        end else if (!same_pair) begin
          cnt_d   = 8'd1;
          state_d = ST_SETTLE;
        end
      end
      default: begin
        cnt_d   = 8'd0;
        state_d = ST_WAIT;
      end
    endcase
  end

  // Slot write, mask and frame publication
  always_comb begin
    slot_val_d = slot_val_q;
    slot_err_d = slot_err_q;
    value_d    = value_q;
    err_d      = err_q;
    valid_d    = frame;
    // The publish cycle clears the mask, but a capture in that same cycle
    // must survive as the first bit of the next frame.
    mask_d     = frame ? 4'h0 : mask_q;
    if (frame) begin
      value_d = slot_val_q;
      err_d   = slot_err_q;
    end
    if (cap) begin
      for (int k = 0; k < 4; k++) begin
        if (idx == 2'(k)) begin
          slot_val_d[4*k +: 4] = dec[3:0];
          slot_err_d[k]        = dec[4];
          mask_d[k]            = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      an_s1_q    <= 4'hF;
      an_s2_q    <= 4'hF;
      seg_s1_q   <= 7'h7F;
      seg_s2_q   <= 7'h7F;
      an_prev_q  <= 4'hF;
      seg_prev_q <= 7'h7F;
      state_q    <= ST_WAIT;
      cnt_q      <= 8'd0;
      mask_q     <= 4'h0;
      slot_val_q <= 16'h0000;
      slot_err_q <= 4'h0;
      value_q    <= 16'h0000;
      err_q      <= 4'h0;
      valid_q    <= 1'b0;
    end else begin
      an_s1_q    <= an_i;
      an_s2_q    <= an_s1_q;
      seg_s1_q   <= seg_i;
      seg_s2_q   <= seg_s1_q;
      an_prev_q  <= an_s2_q;
      seg_prev_q <= seg_s2_q;
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      mask_q     <= mask_d;
      slot_val_q <= slot_val_d;
      slot_err_q <= slot_err_d;
      value_q    <= value_d;
      err_q      <= err_d;
      valid_q    <= valid_d;
    end
  end

  assign value_o = value_q;
  assign err_o   = err_q;
  assign valid_o = valid_q;

endmodule

// File: tb/tb_seg_capture.sv
// -----------------------------------------------------------------------------
// tb_seg_capture
//   Directed scans and randomized bus traffic for seg_capture, checked each
//   cycle against a run-length reference model of the display capture rules.
// -----------------------------------------------------------------------------
module tb_seg_capture;

  localparam int S = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic [15:0] value_o;
  logic [3:0]  err_o;
  logic        valid_o;

  seg_capture #(.STABLE_CYCLES(S)) dut (
    .clk    (clk),
    .rst    (rst),
    .an_i   (an),
    .seg_i  (seg),
    .value_o(value_o),
    .err_o  (err_o),
    .valid_o(valid_o)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int dut_frames = 0;

  // Segment patterns indexed by code; index 10 is the 'E' glyph.
  logic [6:0] pat_tab [11] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12,
                              7'h02, 7'h78, 7'h00, 7'h10, 7'h06};

  // Reference model state
  logic [10:0] dly[$];
  logic [10:0] last_p;
  logic        last_elig;
  int          run;
  logic [3:0]  m_mask;
  logic [3:0]  m_code [4];
  logic        m_err  [4];
  logic [15:0] exp_value;
  logic [3:0]  exp_err;
  logic        exp_valid;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  function automatic void ref_decode(input logic [6:0] s, output logic [3:0] c,
                                     output logic e);
    c = 4'hF;
    e = (s != 7'h7F);
    for (int i = 0; i < 11; i++)
      if (pat_tab[i] == s) begin
        c = 4'(i);
        e = 1'b0;
      end
  endfunction

  function automatic logic ref_elig(input logic [3:0] a);
    return $countones(~a) == 1;
  endfunction

  function automatic int ref_idx(input logic [3:0] a);
    int r = 0;
    for (int i = 0; i < 4; i++) if (!a[i]) r = i;
    return r;
  endfunction

  task automatic model_reset();
    dly.delete();
    dly.push_back({4'hF, 7'h7F});
    dly.push_back({4'hF, 7'h7F});
    last_p    = {4'hF, 7'h7F};
    last_elig = 1'b0;
    run       = 0;
    m_mask    = 4'h0;
    for (int i = 0; i < 4; i++) begin
      m_code[i] = 4'h0;
      m_err[i]  = 1'b0;
    end
    exp_value = 16'h0;
    exp_err   = 4'h0;
    exp_valid = 1'b0;
  endtask

  task automatic step(input logic r, input logic [3:0] a, input logic [6:0] s);
    logic [10:0] p;
    logic        el;
    int          k;
    rst = r;
    an  = a;
    seg = s;
    @(posedge clk);
    if (r) begin
      model_reset();
    end else begin
      p = dly.pop_front();
      dly.push_back({a, s});
      exp_valid = (m_mask == 4'hF);
      if (exp_valid) begin
        exp_value = {m_code[3], m_code[2], m_code[1], m_code[0]};
        exp_err   = {m_err[3], m_err[2], m_err[1], m_err[0]};
        m_mask    = 4'h0;
      end
      el = ref_elig(p[10:7]);
      if (el && last_elig && p == last_p) run++;
      else run = el ? 1 : 0;
      last_p    = p;
      last_elig = el;
      if (el && run == S) begin
        k = ref_idx(p[10:7]);
        ref_decode(p[6:0], m_code[k], m_err[k]);
        m_mask[k] = 1'b1;
      end
    end
    #1;
    chk("valid", 32'(valid_o), 32'(exp_valid));
    chk("value", 32'(value_o), 32'(exp_value));
    chk("err", 32'(err_o), 32'(exp_err));
    if (valid_o === 1'b1) dut_frames++;
  endtask

  task automatic show(input int k, input logic [6:0] s, input int n);
    logic [3:0] a;
    a    = 4'hF;
    a[k] = 1'b0;
    for (int i = 0; i < n; i++) step(1'b0, a, s);
  endtask

  task automatic hold_an(input logic [3:0] a, input int n);
    for (int i = 0; i < n; i++) step(1'b0, a, 7'h7F);
  endtask

  task automatic do_reset();
    step(1'b1, 4'hF, 7'h7F);
    chk("rst_value", 32'(value_o), 32'h0);
    chk("rst_err", 32'(err_o), 32'h0);
    chk("rst_valid", 32'(valid_o), 32'h0);
    dut_frames = 0;
  endtask

  task automatic expect_frames(input string tag, input int nf, input logic [15:0] v,
                               input logic [3:0] e);
    chk({tag, "_frames"}, 32'(dut_frames), 32'(nf));
    chk({tag, "_value"}, 32'(value_o), 32'(v));
    chk({tag, "_err"}, 32'(err_o), 32'(e));
  endtask

  initial begin
    rst = 1'b1;
    an  = 4'hF;
    seg = 7'h7F;
    model_reset();

    // Plain scan of 1,2,3,4
    do_reset();
    show(0, pat_tab[1], 8); show(1, pat_tab[2], 8);
    show(2, pat_tab[3], 8); show(3, pat_tab[4], 8);
    hold_an(4'hF, 6);
    expect_frames("scan", 1, 16'h4321, 4'h0);

    // Segments never settle long enough
    do_reset();
    for (int i = 0; i < 10; i++) show(0, (i % 2) ? pat_tab[1] : pat_tab[2], 3);
    hold_an(4'hF, 6);
    expect_frames("unstable", 0, 16'h0000, 4'h0);

    // 'E' glyph and an unknown pattern
    do_reset();
    show(0, pat_tab[1], 8); show(1, pat_tab[2], 8);
    show(2, 7'h06, 8); show(3, 7'h2A, 8);
    hold_an(4'hF, 6);
    expect_frames("errfrm", 1, 16'hFA21, 4'h8);

    // Ineligible anode patterns between digits
    do_reset();
    show(0, pat_tab[1], 8); show(1, pat_tab[2], 8);
    hold_an(4'b1100, 20);
    show(2, pat_tab[3], 8);
    hold_an(4'b1111, 20);
    show(3, pat_tab[4], 8);
    hold_an(4'hF, 6);
    expect_frames("inelig", 1, 16'h4321, 4'h0);

    // Reset mid-frame discards partial captures
    do_reset();
    show(0, pat_tab[1], 8); show(1, pat_tab[2], 8); show(2, pat_tab[3], 8);
    hold_an(4'hF, 4);
    chk("partial_frames", 32'(dut_frames), 32'h0);
    do_reset();
    show(0, pat_tab[5], 8); show(1, pat_tab[6], 8);
    show(2, pat_tab[7], 8); show(3, pat_tab[8], 8);
    hold_an(4'hF, 6);
    expect_frames("midrst", 1, 16'h8765, 4'h0);

    // Digit 0 recaptured before the frame completes
    do_reset();
    show(0, pat_tab[3], 8); show(0, pat_tab[9], 8);
    show(1, pat_tab[0], 8); show(2, pat_tab[0], 8); show(3, pat_tab[0], 8);
    hold_an(4'hF, 6);
    expect_frames("recap", 1, 16'h0009, 4'h0);

    // Randomized bus traffic against the model
    do_reset();
    for (int t = 0; t < 400; t++) begin
      logic [3:0] a;
      logic [6:0] s;
      int         n;
      int         sel;
      if ($urandom_range(0, 99) < 3) begin
        step(1'b1, 4'hF, 7'h7F);
      end else begin
        a = 4'hF;
        if ($urandom_range(0, 99) < 80) a[$urandom_range(0, 3)] = 1'b0;
        else a = 4'($urandom);
        sel = $urandom_range(0, 99);
        if (sel < 70)      s = pat_tab[$urandom_range(0, 10)];
        else if (sel < 80) s = 7'h7F;
        else               s = 7'($urandom);
        n = $urandom_range(1, 9);
        for (int i = 0; i < n; i++) step(1'b0, a, s);
      end
    end
    hold_an(4'hF, 6);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
